count_ctrl: RTL and testbench
=============================

COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter REPS_W, default 3: width of the repeat field.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 start  input  1  request a counting job; sampled only in IDLE.
REQ-006 limit  input  WIDTH  terminal value of each pass; latched on accepted start.
REQ-007 reps  input  REPS_W  extra passes after the first (total passes = reps+1); latched on accepted start.
REQ-008 up  input  1  1: count 0..limit; 0: count limit..0; latched on accepted start.
REQ-009 abort  input  1  terminate the job in LOAD or RUN.
REQ-010 count  output  WIDTH  current counter value.
REQ-011 busy  output  1  high in LOAD and RUN.
REQ-012 wrap  output  1  one-cycle pulse on the last cycle of each pass.
REQ-013 pass_cnt  output  REPS_W  index of the current pass, 0-based.
REQ-014 done  output  1  one-cycle pulse on normal job completion.

Function
REQ-015 FSM states: IDLE, LOAD, RUN, DONE.
REQ-016 IDLE: start=1 and abort=0 at an edge -> latch limit/reps/up, pass_cnt<=0, go to LOAD.
REQ-017 LOAD (1 cycle): count <= (up ? 0 : limit_latched); go to RUN.
REQ-018 RUN: end value E = (up ? limit_latched : 0); wrap = (state==RUN && count==E), combinational.
REQ-019 RUN, count!=E: count steps by +1 (up) or -1 (down) each cycle.
REQ-020 RUN, count==E and pass_cnt!=reps_latched: pass_cnt+1, count reloads to the start value, stay in RUN.
REQ-021 RUN, count==E and pass_cnt==reps_latched: go to DONE; count holds.
REQ-022 DONE (1 cycle): done=1, then IDLE; count holds its final value in IDLE.
REQ-023 Each pass lasts exactly limit+1 RUN cycles; job length = 1 (LOAD) + (limit+1)*(reps+1) + 1 (DONE) cycles.
REQ-024 limit=0: every pass is a single RUN cycle with wrap=1 and count=0.
REQ-025 abort=1 in LOAD or RUN -> IDLE at the next edge, no done, no further wrap; count holds.
REQ-026 abort is ignored in IDLE and DONE; in IDLE abort=1 blocks a same-cycle start.
REQ-027 start is ignored while busy or in DONE; it is not queued.
REQ-028 Latched parameters do not change during a job regardless of input changes.
REQ-029 count never leaves the range 0..limit_latched during RUN; arithmetic is modulo 2^WIDTH only by construction.

Reset
REQ-030 reset=1 at an edge -> state IDLE, count=0, pass_cnt=0, busy=0, wrap=0, done=0, latched fields cleared.
REQ-031 reset takes priority over start and abort, including in the middle of LOAD, RUN or DONE.

Structure
REQ-032 Package count_ctrl_pkg holds the state enum and the default WIDTH/REPS_W constants.
REQ-033 The counter datapath is a sub-module counter4 (clk, reset, load, load_val, en, up, count); count_ctrl holds only the FSM and the pass/parameter registers.

Verification
REQ-034 limit=3, reps=1, up=1, start pulse -> busy for 9 cycles, count 0,1,2,3,0,1,2,3, wrap on both 3s, then done=1 for one cycle.
REQ-035 limit=5, reps=0, up=0 -> count 5,4,3,2,1,0, a single wrap at 0, done one cycle later, pass_cnt stays 0.
REQ-036 limit=0, reps=2 -> 3 RUN cycles with count=0 and wrap=1 each, pass_cnt 0,1,2, then done.
REQ-037 abort at the 3rd RUN cycle of a limit=7 job -> IDLE next edge, busy=0, no done; a new start is then accepted normally.
REQ-038 reset asserted mid-RUN (pattern 0 at 12 ns, 1 for 33 ns, 0 for 25 ns, then 1) -> all outputs reach reset values at the next edge, start ignored while reset=1.
REQ-039 start held high across a whole job, plus limit/up changed mid-job -> the job uses the latched values only; a second job starts one cycle after DONE.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared types and default sizes for the count_ctrl block.
// Holds the controller state encoding and the default counter/repeat widths.
package count_ctrl_pkg;

  localparam int COUNT_WIDTH_DEF = 4;
  localparam int REPS_W_DEF      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/count_ctrl_counter4.sv
// counter4: loadable up/down counter datapath used by count_ctrl.
// Ports:
//   clk      - system clock, all updates on posedge
//   reset    - synchronous active-high reset, clears count
//   load     - load load_val (has priority over en)
//   load_val - value loaded when load=1
//   en       - step the counter by one in the direction given by up
//   up       - 1: increment, 0: decrement
//   count    - current counter value (registered)
module counter4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next counter value: load wins over step, otherwise hold
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (up) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: sequences a counting job of (reps+1) passes over 0..limit,
// counting up or down, with abort and one-cycle wrap/done pulses.
// Ports:
//   clk, reset         - system clock, synchronous active-high reset
//   start              - request a job (accepted only in IDLE with abort=0)
//   limit, reps, up    - job parameters, latched when a start is accepted
//   abort              - terminate the job while in LOAD or RUN
//   count              - current counter value
//   busy               - high in LOAD and RUN
//   wrap               - high on the last cycle of each pass
//   pass_cnt           - 0-based index of the current pass
//   done               - one-cycle pulse on normal completion
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH  = COUNT_WIDTH_DEF,
  parameter int REPS_W = REPS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  limit,
  input  logic [REPS_W-1:0] reps,
  input  logic              up,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              wrap,
  output logic [REPS_W-1:0] pass_cnt,
  output logic              done
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic [REPS_W-1:0] reps_q, reps_d;
  logic              up_q, up_d;
  logic [REPS_W-1:0] pass_q, pass_d;

  logic              cnt_load_s;
  logic              cnt_en_s;
  logic [WIDTH-1:0]  start_val_s;
  logic [WIDTH-1:0]  end_val_s;
  logic              at_end_s;
  logic [WIDTH-1:0]  count_s;

  // Every pass starts at one end of 0..limit and finishes at the other.
  assign start_val_s = up_q ? {WIDTH{1'b0}} : limit_q;
  assign end_val_s   = up_q ? limit_q : {WIDTH{1'b0}};
  assign at_end_s    = (count_s == end_val_s);

  counter4 #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (start_val_s),
    .en       (cnt_en_s),
    .up       (up_q),
    .count    (count_s)
  );

  // next-state, parameter latching and counter control
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    reps_d     = reps_q;
    up_d       = up_q;
    pass_d     = pass_q;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          limit_d = limit;
          reps_d  = reps;
          up_d    = up;
          pass_d  = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // an abort here leaves the counter untouched
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_load_s = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (at_end_s) begin
          if (pass_q == reps_q) begin
            state_d = ST_DONE;
          end else begin
            // next pass reloads the start value, so each pass is limit+1 cycles
            pass_d     = pass_q + REPS_W'(1);
            cnt_load_s = 1'b1;
            state_d    = ST_RUN;
          end
        end else begin
          cnt_en_s = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and job-parameter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      reps_q  <= '0;
      up_q    <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      reps_q  <= reps_d;
      up_q    <= up_d;
      pass_q  <= pass_d;
    end
  end

  assign count    = count_s;
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign wrap     = (state_q == ST_RUN) && at_end_s;
  assign pass_cnt = pass_q;
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_count_ctrl.sv
module tb_count_ctrl;

  localparam int WIDTH  = 4;
  localparam int REPS_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  limit;
  logic [REPS_W-1:0] reps;
  logic              up;
  logic              abort;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              wrap;
  logic [REPS_W-1:0] pass_cnt;
  logic              done;

  count_ctrl #(.WIDTH(WIDTH), .REPS_W(REPS_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .limit    (limit),
    .reps     (reps),
    .up       (up),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .wrap     (wrap),
    .pass_cnt (pass_cnt),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Expected observable outputs for one cycle of a job.
  typedef struct {
    int cnt;
    int pass;
    bit busy;
    bit wrap;
    bit done;
  } exp_t;

  exp_t q[$];          // remaining cycles of the job in progress
  int   hold_cnt  = 0; // value shown while idle
  int   hold_pass = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Advance the reference model by one clock edge, using the current inputs.
  task automatic model_step();
    exp_t h;
    if (reset) begin
      q.delete();
      hold_cnt  = 0;
      hold_pass = 0;
    end else if (q.size() > 0) begin
      h = q[0];
      if (abort && h.busy) begin
        q.delete();
        hold_cnt  = h.cnt;
        hold_pass = h.pass;
      end else begin
        q.delete(0);
        if (q.size() == 0) begin
          hold_cnt  = h.cnt;
          hold_pass = h.pass;
        end
      end
    end else if (start && !abort) begin
      int lim;
      int r;
      bit u;
      lim = int'(limit);
      r   = int'(reps);
      u   = up;
      q.push_back('{hold_cnt, 0, 1'b1, 1'b0, 1'b0});
      for (int p = 0; p <= r; p++) begin
        for (int i = 0; i <= lim; i++) begin
          q.push_back('{(u ? i : lim - i), p, 1'b1, (i == lim), 1'b0});
        end
      end
      q.push_back('{(u ? lim : 0), r, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (q.size() > 0) e = q[0];
    else e = '{hold_cnt, hold_pass, 1'b0, 1'b0, 1'b0};
    check("count",    32'(count),    32'(e.cnt));
    check("pass_cnt", 32'(pass_cnt), 32'(e.pass));
    check("busy",     32'(busy),     32'(e.busy));
    check("wrap",     32'(wrap),     32'(e.wrap));
    check("done",     32'(done),     32'(e.done));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    limit = '0; reps = '0; up = 1'b0;
    run(2);
    reset = 1'b0;
    run(1);

    // limit=3, reps=1, up: two up passes then done
    limit = 4'd3; reps = 3'd1; up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    run(12);

    // limit=5, reps=0, down
    limit = 4'd5; reps = 3'd0; up = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    run(10);

    // limit=0, reps=2: single-cycle passes
    limit = 4'd0; reps = 3'd2; up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    run(6);

    // abort on the third RUN cycle of a limit=7 job, then a fresh job
    limit = 4'd7; reps = 3'd0; up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    run(3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run(2);
    limit = 4'd2; reps = 3'd1; up = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    run(10);

    // abort in IDLE blocks a same-cycle start
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    run(2);

    // abort during LOAD
    limit = 4'd6; reps = 3'd0; up = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    run(2);

    // reset mid-RUN with start held high
    limit = 4'd9; reps = 3'd1; up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    run(4);
    reset = 1'b1; start = 1'b1;
    run(3);
    reset = 1'b0; start = 1'b0;
    run(2);

    // start held across jobs, parameters changed mid-job
    limit = 4'd4; reps = 3'd1; up = 1'b1; start = 1'b1;
    tick();
    run(4);
    limit = 4'd15; reps = 3'd2; up = 1'b0;
    run(20);
    start = 1'b0;
    run(50);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 39) == 0);
      limit = WIDTH'($urandom_range(0, 15));
      reps  = REPS_W'($urandom_range(0, 3));
      up    = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
